// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS16 pattern generator and checker.
// Holds the sync FSM states, the default taps/seed and the next-bit predictor.
package prbs_pkg;

    localparam int unsigned PRBS_W = 16;
    localparam logic [PRBS_W-1:0] PRBS16_TAPS = 16'hB400;
    localparam logic [PRBS_W-1:0] PRBS16_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } sync_state_t;

    // Next bit the generator will emit, given the last 16 bits seen (h[15] oldest).
    function automatic logic prbs_predict(input logic [PRBS_W-1:0] h,
                                          input logic [PRBS_W-1:0] taps);
        return ^(h & taps);
    endfunction

endpackage

// File: rtl/prbs16_checker_if.sv
// Serial stream input and lock/error status of the PRBS16 checker.
interface prbs16_checker_if #(
    parameter int unsigned ERR_W = 16
);
    import prbs_pkg::*;

    logic             din;
    logic             din_valid;
    logic             clear_err;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;
    sync_state_t      sync_state;

    modport master (
        output din, din_valid, clear_err,
        input  locked, err_pulse, err_count, sync_state
    );

    modport slave (
        input  din, din_valid, clear_err,
        output locked, err_pulse, err_count, sync_state
    );

endinterface

// File: rtl/prbs_predictor.sv
// Received-bit history and prediction of the next PRBS16 bit.
// The history self-seeds from the line, so no local generator state is needed.
module prbs_predictor
    import prbs_pkg::*;
#(
    parameter logic [PRBS_W-1:0] TAPS = PRBS16_TAPS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              din,
    input  logic              din_valid,
    output logic [PRBS_W-1:0] hist,
    output logic              pred_c
);

    always_ff @(posedge clk) begin
        if (reset) begin
            hist <= '0;
        end else if (din_valid) begin
            hist <= {hist[PRBS_W-2:0], din};
        end
    end

    assign pred_c = prbs_predict(hist, TAPS);

endmodule

// File: rtl/prbs16_checker.sv
// Receive-side PRBS16 checker: self-synchronises to the serial stream,
// declares lock after a run of correct predictions, then counts bit errors.
module prbs16_checker
    import prbs_pkg::*;
#(
    parameter logic [PRBS_W-1:0] TAPS        = PRBS16_TAPS,
    parameter int unsigned       LOCK_CNT    = 16,
    parameter int unsigned       UNLOCK_ERRS = 4,
    parameter int unsigned       ERR_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    prbs16_checker_if.slave   bus
);

    localparam int unsigned FILL_W  = $clog2(PRBS_W);
    localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned BAD_W   = $clog2(UNLOCK_ERRS + 1);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    logic [PRBS_W-1:0]  hist;
    logic               pred_c;
    logic               match_c;

    sync_state_t        state;
    logic [FILL_W-1:0]  fill_cnt;
    logic [MATCH_W-1:0] match_cnt;
    logic [BAD_W-1:0]   bad_cnt;
    logic               locked;
    logic               err_pulse;
    logic [ERR_W-1:0]   err_count;

    prbs_predictor #(
        .TAPS (TAPS)
    ) u_predictor (
        .clk       (clk),
        .reset     (reset),
        .din       (bus.din),
        .din_valid (bus.din_valid),
        .hist      (hist),
        .pred_c    (pred_c)
    );

    assign match_c = (pred_c == bus.din);

    // Sync FSM, lock/unlock counters and the error counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FILL;
            fill_cnt  <= '0;
            match_cnt <= '0;
            bad_cnt   <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (bus.din_valid) begin
                case (state)
                    FILL: begin
                        if (fill_cnt == FILL_W'(PRBS_W - 1)) begin
                            state     <= CHECK;
                            fill_cnt  <= '0;
                            match_cnt <= '0;
                        end else begin
                            fill_cnt <= fill_cnt + FILL_W'(1);
                        end
                    end
                    CHECK: begin
                        // An all-zero history predicts zeros forever, so it must not lock.
                        if (match_c && (hist != '0)) begin
                            if (match_cnt == MATCH_W'(LOCK_CNT - 1)) begin
                                state     <= LOCKED;
                                locked    <= 1'b1;
                                bad_cnt   <= '0;
                                match_cnt <= '0;
                            end else begin
                                match_cnt <= match_cnt + MATCH_W'(1);
                            end
                        end else begin
                            match_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        if (match_c) begin
                            bad_cnt <= '0;
                        end else begin
                            err_pulse <= 1'b1;
                            if (err_count != ERR_MAX) begin
                                err_count <= err_count + ERR_W'(1);
                            end
                            if (bad_cnt == BAD_W'(UNLOCK_ERRS - 1)) begin
                                state    <= FILL;
                                locked   <= 1'b0;
                                fill_cnt <= '0;
                                bad_cnt  <= '0;
                            end else begin
                                bad_cnt <= bad_cnt + BAD_W'(1);
                            end
                        end
                    end
                    default: begin
                        state  <= FILL;
                        locked <= 1'b0;
                    end
                endcase
            end
            // Clear wins over a same-edge increment; the pulse is unaffected.
            if (bus.clear_err) begin
                err_count <= '0;
            end
        end
    end

    assign bus.locked     = locked;
    assign bus.err_pulse  = err_pulse;
    assign bus.err_count  = err_count;
    assign bus.sync_state = state;

endmodule
